// File: rtl/access_request_queue_pkg.sv
// Shared types and constants for the access request queue and its age tracker.
package arq_pkg;

    localparam int ARQ_DATA_WIDTH = 132;
    localparam int ARQ_AGE_W      = 8;

    typedef logic [ARQ_DATA_WIDTH-1:0] arq_word_t;

    function automatic int arq_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/access_request_queue_if.sv
// Requester-side push handshake plus scheduler-leg request/grant signals of one queue.
interface access_request_queue_if
    import arq_pkg::*;
#(
    parameter int DATA_WIDTH = ARQ_DATA_WIDTH,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  push_valid;
    logic                  push_ready;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  req;
    logic [DATA_WIDTH-1:0] d_OUT;
    logic                  serv;
    logic                  urgent;
    logic [CNT_W-1:0]      count;

    modport master (
        output push_valid, push_data, serv,
        input  push_ready, req, d_OUT, urgent, count
    );

    modport slave (
        input  push_valid, push_data, serv,
        output push_ready, req, d_OUT, urgent, count
    );

endinterface

// File: rtl/access_request_queue_age_tracker.sv
// Saturating wait counter for the current head entry; flags urgent once the limit is reached.
module arq_age_tracker
    import arq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 head_valid,
    input  logic                 pop,
    input  logic [ARQ_AGE_W-1:0] limit,
    output logic                 urgent
);

    logic [ARQ_AGE_W-1:0] r_age;

    // A pop hands the leg to the next head, which starts waiting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else if (!head_valid || pop) begin
            r_age <= '0;
        end else if (r_age < limit) begin
            r_age <= r_age + ARQ_AGE_W'(1);
        end
    end

    assign urgent = head_valid && (r_age >= limit);

endmodule

// File: rtl/access_request_queue.sv
// Per-requester FIFO feeding one scheduler-tree leaf; head word drives req/d_OUT, serv pops.
// Optional same-cycle bypass of an empty queue when ARQ_BYPASS_EN is defined.
module access_request_queue
    import arq_pkg::*;
#(
    parameter int DATA_WIDTH = ARQ_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int AGE_LIMIT  = 15
)(
    input  logic                  clk,
    input  logic                  rst_n,
    access_request_queue_if.slave bus
);

    localparam int PTR_W = arq_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_stored;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_stored = (r_count != '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_pop    = bus.serv && w_stored;

`ifdef ARQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass  = !w_stored && bus.push_valid;
    // A bypassed word granted in the same cycle never touches storage.
    assign w_push    = bus.push_valid && !w_full && !(w_bypass && bus.serv);
    assign bus.req   = w_stored || w_bypass;
    assign bus.d_OUT = w_stored ? r_mem[r_rd_ptr] : (w_bypass ? bus.push_data : '0);
`else
    assign w_push    = bus.push_valid && !w_full;
    assign bus.req   = w_stored;
    assign bus.d_OUT = w_stored ? r_mem[r_rd_ptr] : '0;
`endif

    assign bus.push_ready = !w_full;
    assign bus.count      = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    arq_age_tracker u_age (
        .clk        (clk),
        .rst_n      (rst_n),
        .head_valid (w_stored),
        .pop        (w_pop),
        .limit      (ARQ_AGE_W'(AGE_LIMIT)),
        .urgent     (bus.urgent)
    );

endmodule

// File: tb/tb_access_request_queue.sv
// Self-checking bench for access_request_queue against a queue-based reference model.
module tb_access_request_queue;
   import arq_pkg::*;

   localparam int DW    = ARQ_DATA_WIDTH;
   localparam int DEPTH = 4;
   localparam int LIMIT = 15;
`ifdef ARQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   always #5 clk_sys = ~clk_sys;

   access_request_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   access_request_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AGE_LIMIT(LIMIT)) dut (
      .clk   (clk_sys),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int        n_chk = 0;
   int        n_err = 0;
   arq_word_t mdl_q[$];
   int        mdl_age = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic arq_word_t rnd_word();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   // Drive one cycle, compare all outputs with the model, then advance the model at the edge.
   task automatic step(input logic pv, input arq_word_t pd, input logic sv);
      int        sz;
      logic      byp;
      arq_word_t e_d;
      @(negedge clk_sys);
      bus.push_valid = pv;
      bus.push_data  = pd;
      bus.serv       = sv;
      #1;
      sz  = mdl_q.size();
      byp = BYP && (sz == 0) && pv;
      e_d = (sz != 0) ? mdl_q[0] : (byp ? pd : '0);
      chk("req",        bus.req,        (sz != 0) || byp);
      chk("d_OUT",      bus.d_OUT,      e_d);
      chk("count",      bus.count,      sz);
      chk("push_ready", bus.push_ready, sz < DEPTH);
      chk("urgent",     bus.urgent,     (sz != 0) && (mdl_age >= LIMIT));
      @(posedge clk_sys);
      if (sz == 0 || sv) mdl_age = 0;
      else if (mdl_age < LIMIT) mdl_age++;
      if (!(byp && sv)) begin
         if (sv && sz != 0) void'(mdl_q.pop_front());
         if (pv && sz < DEPTH) mdl_q.push_back(pd);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      bus.push_valid = 1'b0;
      bus.serv       = 1'b0;
      rst_n          = 1'b0;
      #1;
      chk("rst_req",    bus.req,        1'b0);
      chk("rst_count",  bus.count,      0);
      chk("rst_urgent", bus.urgent,     1'b0);
      chk("rst_ready",  bus.push_ready, 1'b1);
      chk("rst_d_OUT",  bus.d_OUT,      '0);
      mdl_q.delete();
      mdl_age = 0;
      @(negedge clk_sys);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bus.push_valid = 1'b0;
      bus.push_data  = '0;
      bus.serv       = 1'b0;
      repeat (3) @(posedge clk_sys);
      do_reset();
      step(1'b0, '0, 1'b0);

      // push one word, idle: head visible next cycle
      step(1'b1, DW'(1), 1'b0);
      #2;
      chk("t1_req",    bus.req,    1'b1);
      chk("t1_d_OUT",  bus.d_OUT,  DW'(1));
      chk("t1_count",  bus.count,  1);
      chk("t1_urgent", bus.urgent, 1'b0);

      // fill, overflow attempt, then drain in order
      do_reset();
      for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
      #2;
      chk("t2_ready", bus.push_ready, 1'b0);
      chk("t2_count", bus.count,      4);
      step(1'b1, DW'(5), 1'b0);
      #2;
      chk("t2_drop_count", bus.count, 4);
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk("t3_order", bus.d_OUT, DW'(i));
         step(1'b0, '0, 1'b1);
      end
      #2;
      chk("t3_req",   bus.req,        1'b0);
      chk("t3_d_OUT", bus.d_OUT,      '0);
      chk("t3_ready", bus.push_ready, 1'b1);

      // simultaneous push/pop keeps occupancy and wraps pointers
      do_reset();
      step(1'b1, DW'('h10), 1'b0);
      step(1'b1, DW'('h11), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, DW'('h20 + i), 1'b1);
      #2;
      chk("t4_count", bus.count, 2);
      chk("t4_head",  bus.d_OUT, DW'('h21));
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      // head ages to the limit, urgent clears after pop
      do_reset();
      step(1'b1, DW'('h77), 1'b0);
      repeat (14) step(1'b0, '0, 1'b0);
      #2;
      chk("t5_not_yet", bus.urgent, 1'b0);
      step(1'b0, '0, 1'b0);
      #2;
      chk("t5_urgent", bus.urgent, 1'b1);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      #2;
      chk("t5_cleared", bus.urgent, 1'b0);

`ifdef ARQ_BYPASS_EN
      do_reset();
      step(1'b1, DW'('hAB), 1'b1);
      #2;
      chk("t6_count", bus.count, 0);
`endif

      // reset with entries present
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 1'b0);
      do_reset();
      step(1'b0, '0, 1'b0);

      // randomized traffic with varying grant pressure
      for (int i = 0; i < 800; i++) begin
         int sv_pct;
         int pv_pct;
         case (i / 200)
            0:       begin sv_pct = 50; pv_pct = 60; end
            1:       begin sv_pct = 5;  pv_pct = 20; end
            2:       begin sv_pct = 90; pv_pct = 80; end
            default: begin sv_pct = 30; pv_pct = 50; end
         endcase
         step($urandom_range(99) < pv_pct, rnd_word(), $urandom_range(99) < sv_pct);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
